// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N-way selector.
package mux_pkg;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Select width for an n-input mux; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational N-way, WIDTH-bit selector.
// Any select value without a matching input falls back to the last input.
module mux_n_comb
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned NUM_IN = 8,
  localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_data
);

  // Last input is the default; an exact index match overrides it.
  always_comb begin
    o_data = i_data[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input selector with a registered output and valid/ready on both sides.
// A two-entry skid buffer keeps full throughput while in_ready stays registered.
// Optional macro MUX_SEL_CHECK_EN: out-of-range selects store zero and raise a
// sticky sel_err; without it they pick the last input and sel_err is tied low.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned NUM_IN = 8,
  localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_err
);

  state_e            r_state;
  logic [WIDTH-1:0]  r_main;
  logic [WIDTH-1:0]  r_skid;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_sel_err;

  logic [WIDTH-1:0]  w_mux_data;
  logic [WIDTH-1:0]  w_sel_data;
  logic              w_accept;
  logic              w_emit;

  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = r_out_valid & out_ready;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .i_data (in_data),
    .i_sel  (in_sel),
    .o_data (w_mux_data)
  );

`ifdef MUX_SEL_CHECK_EN
  localparam logic [SEL_W:0] LP_NUM_IN = (SEL_W+1)'(NUM_IN);
  logic w_oor;

  // Out-of-range select replaces the item with zero.
  assign w_oor      = ({1'b0, in_sel} >= LP_NUM_IN);
  assign w_sel_data = w_oor ? '0 : w_mux_data;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && w_oor) begin
      r_sel_err <= 1'b1;
    end
  end
`else
  assign w_sel_data = w_mux_data;

  // Error reporting disabled in this build.
  always_ff @(posedge clk) begin
    r_sel_err <= 1'b0;
  end
`endif

  // Buffer occupancy FSM: main register feeds the output, skid absorbs one stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main      <= w_sel_data;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_accept && !w_emit) begin
            r_skid     <= w_sel_data;
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_emit && !w_accept) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end else if (w_emit && w_accept) begin
            r_main <= w_sel_data;
          end
        end
        TWO: begin
          if (w_emit) begin
            r_main     <= r_skid;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign sel_err   = r_sel_err;

endmodule
